// File: rtl/xillybus_stream_pkg.sv
// Shared types and helpers for the Xillybus host-write stream arbiter.
package xillybus_stream_pkg;

  localparam int NCH_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EOF   = 2'd2
  } arb_state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/xillybus_chan_fifo.sv
// Per-channel synchronous FIFO; count is one bit wider than the pointers so full is unambiguous.
module xillybus_chan_fifo
  import xillybus_stream_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DW-1:0]           din,
  input  logic                    pop,
  output logic [DW-1:0]           dout,
  output logic [clog2(DEPTH):0]   count,
  output logic                    empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rd_ptr];
  assign empty   = (count == '0);

  // Storage is never reset; emptiness is carried entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xillybus_stream_arbiter.sv
// Merges NCH host-write channels into one registered valid/ready stream with
// round-robin bursts and an end-of-file beat after each channel close.
module xillybus_stream_arbiter
  import xillybus_stream_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int BURST = 8
) (
  input  logic                   bus_clk_w,
  input  logic                   bus_rst_w,
  input  logic [NCH*DW-1:0]      user_w_data_w,
  input  logic [NCH-1:0]         user_w_wren_w,
  input  logic [NCH-1:0]         user_w_open_w,
  output logic [NCH-1:0]         user_w_full_w,
  output logic [DW-1:0]          m_data_w,
  output logic [clog2(NCH)-1:0]  m_chan_w,
  output logic                   m_eof_w,
  output logic                   m_valid_w,
  input  logic                   m_ready_w,
  output logic [NCH-1:0]         overflow_w
);

  localparam int CW = clog2(NCH);
  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
  localparam logic [15:0] BURST_LAST = 16'(BURST - 1);

  if (NCH < 2 || NCH > NCH_MAX) begin : g_bad_nch
    $error("xillybus_stream_arbiter: NCH out of range");
  end

  arb_state_t    state;
  arb_state_t    state_next;
  logic [CW-1:0] gnt;
  logic [CW-1:0] sel;
  logic [CW-1:0] last_grant;
  logic [CW-1:0] rr_idx;
  logic          grab;
  logic [15:0]   burst_cnt;
  logic          load_data;
  logic          load_eof;

  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] empty;
  logic [NCH-1:0] eof_pending;
  logic [NCH-1:0] eof_clr;
  logic [NCH-1:0] open_q;
  logic [AW:0]    count [NCH];
  logic [DW-1:0]  dout  [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    xillybus_chan_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (bus_clk_w),
      .rst   (bus_rst_w),
      .push  (push[k]),
      .din   (user_w_data_w[k*DW +: DW]),
      .pop   (pop[k]),
      .dout  (dout[k]),
      .count (count[k]),
      .empty (empty[k])
    );
    // A pending EOF blocks further writes until the marker has been delivered.
    assign user_w_full_w[k] = (count[k] == FULL_CNT) || eof_pending[k];
  end

  assign push = user_w_wren_w & ~user_w_full_w;

  // Beats are launched only while downstream is ready, so words stay in the
  // FIFO (and count toward full) during back-pressure.
  always_comb begin
    state_next = state;
    sel        = gnt;
    rr_idx     = '0;
    grab       = 1'b0;
    pop        = '0;
    eof_clr    = '0;
    load_data  = 1'b0;
    load_eof   = 1'b0;
    case (state)
      IDLE: begin
        for (int i = 1; i <= NCH; i++) begin
          rr_idx = CW'((int'(last_grant) + i) % NCH);
          if (!grab && (!empty[rr_idx] || eof_pending[rr_idx])) begin
            grab       = 1'b1;
            sel        = rr_idx;
            state_next = empty[rr_idx] ? EOF : GRANT;
          end
        end
      end
      GRANT: begin
        if (empty[gnt]) begin
          state_next = IDLE;
        end else if (m_ready_w) begin
          pop[gnt]  = 1'b1;
          load_data = 1'b1;
          if (count[gnt] == ONE_CNT || burst_cnt == BURST_LAST) state_next = IDLE;
        end
      end
      EOF: begin
        if (m_valid_w && m_eof_w) begin
          if (m_ready_w) begin
            eof_clr[gnt] = 1'b1;
            state_next   = IDLE;
          end
        end else if (m_ready_w) begin
          load_eof = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge bus_clk_w or posedge bus_rst_w) begin
    if (bus_rst_w) state <= IDLE;
    else           state <= state_next;
  end

  always_ff @(posedge bus_clk_w or posedge bus_rst_w) begin
    if (bus_rst_w) begin
      gnt         <= '0;
      last_grant  <= CW'(NCH - 1);
      burst_cnt   <= '0;
      open_q      <= '0;
      eof_pending <= '0;
      overflow_w  <= '0;
      m_valid_w   <= 1'b0;
      m_data_w    <= '0;
      m_chan_w    <= '0;
      m_eof_w     <= 1'b0;
    end else begin
      if (grab) begin
        gnt        <= sel;
        last_grant <= sel;
        burst_cnt  <= '0;
      end else if (load_data) begin
        burst_cnt  <= burst_cnt + 16'd1;
      end
      open_q      <= user_w_open_w;
      eof_pending <= (eof_pending & ~eof_clr) | (open_q & ~user_w_open_w);
      overflow_w  <= overflow_w | (user_w_wren_w & user_w_full_w);
      if (load_data) begin
        m_valid_w <= 1'b1;
        m_data_w  <= dout[gnt];
        m_chan_w  <= gnt;
        m_eof_w   <= 1'b0;
      end else if (load_eof) begin
        m_valid_w <= 1'b1;
        m_data_w  <= '0;
        m_chan_w  <= gnt;
        m_eof_w   <= 1'b1;
      end else if (m_ready_w) begin
        m_valid_w <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xillybus_stream_arbiter.sv
// Bench for xillybus_stream_arbiter: per-channel expected queues checked by a negedge monitor.
module tb_xillybus_stream_arbiter;

  localparam int NCH   = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int BURST = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*DW-1:0] wdata;
  logic [NCH-1:0]    wren;
  logic [NCH-1:0]    open;
  logic [NCH-1:0]    full;
  logic [DW-1:0]     m_data;
  logic [0:0]        m_chan;
  logic              m_eof;
  logic              m_valid;
  logic              m_ready;
  logic [NCH-1:0]    overflow;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [DW:0]   q0[$];
  logic [DW:0]   q1[$];
  int            log_chan[$];
  logic [DW-1:0] log_data[$];
  logic          log_eof[$];
  int            log_cyc[$];

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [0:0]    prev_chan;
  logic          prev_eof;
  logic [DW:0]   mon_got;
  logic [DW:0]   mon_want;

  xillybus_stream_arbiter #(
    .NCH   (NCH),
    .DW    (DW),
    .DEPTH (DEPTH),
    .BURST (BURST)
  ) dut (
    .bus_clk_w     (clk),
    .bus_rst_w     (rst),
    .user_w_data_w (wdata),
    .user_w_wren_w (wren),
    .user_w_open_w (open),
    .user_w_full_w (full),
    .m_data_w      (m_data),
    .m_chan_w      (m_chan),
    .m_eof_w       (m_eof),
    .m_valid_w     (m_valid),
    .m_ready_w     (m_ready),
    .overflow_w    (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void exp_push(input int ch, input logic [DW:0] v);
    if (ch == 0) q0.push_back(v);
    else         q1.push_back(v);
  endfunction

  function automatic void clear_model();
    q0.delete();
    q1.delete();
    log_chan.delete();
    log_data.delete();
    log_eof.delete();
    log_cyc.delete();
  endfunction

  // Monitor: every accepted beat must be the front of its channel's expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          tests++;
          if (m_valid !== 1'b1 || m_data !== prev_data || m_chan !== prev_chan || m_eof !== prev_eof) begin
            fails++;
            $display("FAIL stall_hold: got v=%b d=%h c=%0d e=%b, want v=1 d=%h c=%0d e=%b",
                     m_valid, m_data, m_chan, m_eof, prev_data, prev_chan, prev_eof);
          end
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
          mon_got = {m_eof, m_data};
          tests++;
          if ((m_chan == 1'b0 && q0.size() == 0) || (m_chan == 1'b1 && q1.size() == 0)) begin
            fails++;
            $display("FAIL beat_unexpected: got chan=%0d eof=%b data=%h, want no beat", m_chan, m_eof, m_data);
          end else begin
            if (m_chan == 1'b0) mon_want = q0.pop_front();
            else                mon_want = q1.pop_front();
            if (mon_got !== mon_want) begin
              fails++;
              $display("FAIL beat_value ch%0d: got eof/data=%h, want %h", m_chan, mon_got, mon_want);
            end
          end
          log_chan.push_back(int'(m_chan));
          log_data.push_back(m_data);
          log_eof.push_back(m_eof);
          log_cyc.push_back(cyc);
        end
        prev_stall = (m_valid === 1'b1 && m_ready === 1'b0);
        prev_data  = m_data;
        prev_chan  = m_chan;
        prev_eof   = m_eof;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [NCH-1:0] open_val);
    rst  = 1'b1;
    wren = '0;
    open = open_val;
    clear_model();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_ch(input int ch, input logic [DW-1:0] d);
    wren = '0;
    wdata[ch*DW +: DW] = d;
    wren[ch] = 1'b1;
    exp_push(ch, {1'b0, d});
    tick();
    wren = '0;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (m_valid !== 1'b0)  begin fails++; $display("FAIL rst_valid: got %b, want 0", m_valid); end
    tests++; if (m_data !== '0)     begin fails++; $display("FAIL rst_data: got %h, want 0", m_data); end
    tests++; if (m_chan !== '0)     begin fails++; $display("FAIL rst_chan: got %0d, want 0", m_chan); end
    tests++; if (m_eof !== 1'b0)    begin fails++; $display("FAIL rst_eof: got %b, want 0", m_eof); end
    tests++; if (full !== '0)       begin fails++; $display("FAIL rst_full: got %b, want 00", full); end
    tests++; if (overflow !== '0)   begin fails++; $display("FAIL rst_overflow: got %b, want 00", overflow); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    m_ready = 1'b1;
    wdata[31:0] = 32'h1111_1111;
    wren = 2'b01;
    exp_push(0, {1'b0, 32'h1111_1111});
    tick();
    wren = '0;
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL lat_t0_valid: got %b, want 0", m_valid); end
    tick();
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL lat_t1_valid: got %b, want 0", m_valid); end
    tick();
    tests++;
    if (m_valid !== 1'b1 || m_data !== 32'h1111_1111 || m_chan !== 1'b0) begin
      fails++;
      $display("FAIL lat_t2_beat: got v=%b d=%h c=%0d, want v=1 d=11111111 c=0", m_valid, m_data, m_chan);
    end
    repeat (4) tick();
  endtask

  task automatic test_open_low_reset();
    do_reset(2'b10);
    m_ready = 1'b1;
    repeat (8) tick();
    tests++; if (log_chan.size() != 0 || m_valid !== 1'b0) begin fails++; $display("FAIL open_low_beat: got beats=%0d v=%b, want 0 0", log_chan.size(), m_valid); end
    tests++; if (full[0] !== 1'b0) begin fails++; $display("FAIL open_low_full: got %b, want 0", full[0]); end
    open = 2'b11;
    repeat (3) tick();
    tests++; if (log_chan.size() != 0) begin fails++; $display("FAIL open_rise_beat: got beats=%0d, want 0", log_chan.size()); end
  endtask

  task automatic test_burst_order();
    int exp_ch;
    do_reset(2'b11);
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wdata = {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
      wren  = 2'b11;
      exp_push(0, {1'b0, 32'hA000_0000 + 32'(i)});
      exp_push(1, {1'b0, 32'hB000_0000 + 32'(i)});
      tick();
    end
    wren = '0;
    for (int n = 0; n < 200 && log_chan.size() < 24; n++) tick();
    tests++;
    if (log_chan.size() != 24) begin
      fails++;
      $display("FAIL burst_count: got %0d beats, want 24", log_chan.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        exp_ch = (i < 8) ? 0 : (i < 16) ? 1 : (i < 20) ? 0 : 1;
        tests++;
        if (log_chan[i] != exp_ch) begin
          fails++;
          $display("FAIL burst_order[%0d]: got ch%0d, want ch%0d", i, log_chan[i], exp_ch);
        end
      end
      for (int i = 1; i < BURST; i++) begin
        tests++;
        if (log_cyc[i] != log_cyc[i-1] + 1) begin
          fails++;
          $display("FAIL burst_rate[%0d]: got gap %0d cycles, want 1", i, log_cyc[i] - log_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset(2'b11);
    m_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      tests++;
      if (full[0] !== ((i == DEPTH) ? 1'b1 : 1'b0)) begin
        fails++;
        $display("FAIL ovf_full_before_write%0d: got %b, want %b", i + 1, full[0], (i == DEPTH));
      end
      wdata[31:0] = 32'hC000_0000 + 32'(i);
      wren = 2'b01;
      if (i < DEPTH) exp_push(0, {1'b0, 32'hC000_0000 + 32'(i)});
      tick();
    end
    wren = '0;
    tests++; if (overflow !== 2'b01) begin fails++; $display("FAIL ovf_flag: got %b, want 01", overflow); end
    repeat (3) tick();
    m_ready = 1'b1;
    for (int n = 0; n < 200 && q0.size() != 0; n++) tick();
    repeat (4) tick();
    tests++; if (q0.size() != 0 || log_chan.size() != DEPTH) begin fails++; $display("FAIL ovf_drain: got beats=%0d left=%0d, want %0d 0", log_chan.size(), q0.size(), DEPTH); end
    tests++; if (full[0] !== 1'b0) begin fails++; $display("FAIL ovf_full_after_drain: got %b, want 0", full[0]); end
    tests++; if (overflow !== 2'b01) begin fails++; $display("FAIL ovf_sticky: got %b, want 01", overflow); end
  endtask

  task automatic test_async_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) write_ch(0, 32'hE000_0001 + 32'(i));
    tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL ar_pre_valid: got %b, want 1", m_valid); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL ar_valid: got %b, want 0", m_valid); end
    tests++; if (m_data !== '0)    begin fails++; $display("FAIL ar_data: got %h, want 0", m_data); end
    tests++; if (m_chan !== '0 || m_eof !== 1'b0) begin fails++; $display("FAIL ar_chan_eof: got c=%0d e=%b, want 0 0", m_chan, m_eof); end
    tests++; if (full !== '0 || overflow !== '0) begin fails++; $display("FAIL ar_flags: got full=%b ovf=%b, want 00 00", full, overflow); end
    clear_model();
    tick();
    rst = 1'b0;
    tick();
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL ar_first_cycle: got v=%b, want 0", m_valid); end
    repeat (8) tick();
    tests++; if (log_chan.size() != 0 || m_valid !== 1'b0) begin fails++; $display("FAIL ar_no_beats: got beats=%0d v=%b, want 0 0", log_chan.size(), m_valid); end
  endtask

  task automatic test_eof();
    logic found;
    do_reset(2'b11);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) write_ch(1, 32'hD000_0000 + 32'(i));
    open[1] = 1'b0;
    exp_push(1, {1'b1, 32'h0});
    tick();
    tests++; if (full[1] !== 1'b1) begin fails++; $display("FAIL eof_full_set: got %b, want 1", full[1]); end
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (m_valid === 1'b1 && m_eof === 1'b1 && m_ready === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL eof_timeout: got no eof beat in 50 cycles, want one");
    end else begin
      if (full[1] !== 1'b1 || m_chan !== 1'b1 || m_data !== '0) begin
        fails++;
        $display("FAIL eof_beat: got full=%b c=%0d d=%h, want 1 1 0", full[1], m_chan, m_data);
      end
      @(posedge clk);
      #1;
      tests++; if (full[1] !== 1'b0) begin fails++; $display("FAIL eof_full_clear: got %b, want 0", full[1]); end
    end
    tick();
    tests++;
    if (log_chan.size() != 4 || q1.size() != 0 || log_eof[log_eof.size()-1] !== 1'b1) begin
      fails++;
      $display("FAIL eof_sequence: got beats=%0d left=%0d, want 4 0 ending in eof", log_chan.size(), q1.size());
    end
    open[1] = 1'b1;
    tick();
  endtask

  task automatic test_stall();
    do_reset(2'b11);
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_ch(0, $urandom);
    for (int i = 0; i < 40; i++) begin
      m_ready = ((i % 4) == 0 || (i % 4) == 3);
      tick();
    end
    m_ready = 1'b1;
    repeat (10) tick();
    tests++;
    if (log_chan.size() != 6 || q0.size() != 0) begin
      fails++;
      $display("FAIL stall_stream: got beats=%0d left=%0d, want 6 0", log_chan.size(), q0.size());
    end
  endtask

  task automatic test_random();
    int            cnt [NCH];
    logic [NCH-1:0] close;
    logic [DW-1:0]  d;
    for (int r = 0; r < 6; r++) begin
      cnt[0] = 0;
      cnt[1] = 0;
      for (int c = 0; c < 20; c++) begin
        m_ready = 1'($urandom_range(0, 1));
        wren = '0;
        for (int ch = 0; ch < NCH; ch++) begin
          if (cnt[ch] < 12 && $urandom_range(0, 1) == 1) begin
            tests++;
            if (full[ch] !== 1'b0) begin fails++; $display("FAIL rand_full ch%0d: got %b, want 0", ch, full[ch]); end
            d = $urandom;
            wdata[ch*DW +: DW] = d;
            wren[ch] = 1'b1;
            exp_push(ch, {1'b0, d});
            cnt[ch]++;
          end
        end
        tick();
      end
      wren = '0;
      close = 2'($urandom_range(0, 3));
      for (int ch = 0; ch < NCH; ch++) if (close[ch]) exp_push(ch, {1'b1, 32'h0});
      open = open & ~close;
      tick();
      m_ready = 1'b1;
      for (int n = 0; n < 300 && (q0.size() != 0 || q1.size() != 0); n++) tick();
      tick();
      tests++;
      if (q0.size() != 0 || q1.size() != 0) begin
        fails++;
        $display("FAIL rand_drain round%0d: got left=%0d/%0d, want 0/0", r, q0.size(), q1.size());
      end
      open = 2'b11;
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    wren    = '0;
    open    = '1;
    wdata   = '0;
    m_ready = 1'b1;
    test_reset();
    test_latency();
    test_open_low_reset();
    test_burst_order();
    test_overflow();
    test_async_reset();
    test_eof();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
